// File: rtl/sub_result_display_if.sv
// Capture-side inputs and display-side outputs of the subtractor result display.
interface sub_result_display_if;
    logic       load;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] diff;
    logic       neg;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    modport master (output load, a, b, diff, neg,
                    input  seg, dp, an, frame_tick);
    modport slave  (input  load, a, b, diff, neg,
                    output seg, dp, an, frame_tick);
endinterface

// File: rtl/sub_result_display.sv
// Captures A, B and the subtractor result on a button edge and scans them
// onto a 4-digit common-anode seven-segment display with blanking gaps.
module sub_result_display #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               rst_n,
    sub_result_display_if.slave bus
);
    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      idx, idx_n;

    logic            sync1, sync2, prev, cap;
    logic [3:0]      cap_a, cap_b;
    logic [7:0]      cap_mag, mag_in;
    logic            cap_neg;

    logic [3:0]      nib;
    logic            nib_dp;
    logic [6:0]      seg_q, seg_n;
    logic [3:0]      an_q, an_n;
    logic            dp_q, dp_n, tick_q, tick_n;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // The button is asynchronous: two flops of synchronisation, then edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.load;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign cap    = sync2 & ~prev;
    assign mag_in = bus.neg ? (~bus.diff + 8'd1) : bus.diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_mag <= '0;
            cap_neg <= 1'b0;
        end else if (cap) begin
            cap_a   <= bus.a;
            cap_b   <= bus.b;
            cap_mag <= mag_in;
            cap_neg <= bus.neg;
        end
    end

    always_comb begin
        nib    = cap_a;
        nib_dp = 1'b1;
        case (idx)
            2'd0: nib = cap_mag[3:0];
            2'd1: begin
                nib    = cap_mag[7:4];
                nib_dp = ~cap_neg;
            end
            2'd2: nib = cap_b;
            default: nib = cap_a;
        endcase
    end

    // Display content is latched only when a DRIVE phase starts, so a capture
    // never changes a digit that is already lit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        an_n    = an_q;
        seg_n   = seg_q;
        dp_n    = dp_q;
        tick_n  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = DRIVE;
                    an_n    = ~(4'b0001 << idx);
                    seg_n   = decode(nib);
                    dp_n    = nib_dp;
                end
            end
            default: begin
                if (cnt == CW'(DIGIT_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = BLANK;
                    idx_n   = idx + 2'd1;
                    an_n    = '1;
                    seg_n   = '1;
                    dp_n    = 1'b1;
                    tick_n  = (idx == 2'd3);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= '0;
            an_q   <= '1;
            seg_q  <= '1;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            an_q   <= an_n;
            seg_q  <= seg_n;
            dp_q   <= dp_n;
            tick_q <= tick_n;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: doc/sub_result_display.md
Name: sub_result_display

Overview:
- Downstream consumer of the subtractor stage. Captures operands A and B and the 8-bit difference plus its sign flag on a button press.
- Shows the captured values on the board's 4-digit, common-anode seven-segment display using time-multiplexed scanning.
- Digit layout: digit3 = A, digit2 = B, digits1:0 = magnitude of the difference in hex. The decimal point on digit1 marks a negative result.

Parameters:
- DIGIT_CYCLES, 100000: clk cycles each digit is driven (DRIVE phase); must be >= 2.
- BLANK_CYCLES, 16: clk cycles all anodes are off between digits (ghost suppression); must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture request, asynchronous (push-button); rising edge captures
- a  input  4  operand A
- b  input  4  operand B
- diff  input  8  subtractor result, two's complement
- neg  input  1  result-negative flag from the subtractor
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low, one-hot when driving; an[0] = rightmost digit
- frame_tick  output  1  one-cycle pulse when digit index wraps from 3 to 0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
  - Captured A/B/mag/neg = 0.
  - Digit index = 0, cycle counter = 0, state = BLANK.
  - Both load synchronizer flops and the edge-detect flop = 0.
- Reset mid-scan aborts the current digit immediately; scanning restarts at digit0 with a BLANK phase.
- Load path:
  - load passes through a 2-flop synchronizer, then a rising-edge detector using a prior-value flop.
  - The capture pulse fires 3 clk edges after load is first sampled high.
  - On the capture pulse, register a, b and neg, and set mag = neg ? (~diff + 1) mod 256 : diff.
  - Holding load high produces exactly one capture. A load held high through reset release produces one capture, because the edge is detected against the reset value 0.
  - Captured values are used from the next DRIVE phase that starts after capture. Values already latched for the current DRIVE phase do not change mid-phase.
- Scan state machine:
  - BLANK: an=1111, seg=1111111, dp=1. The counter counts 0..BLANK_CYCLES-1; at terminal count, clear the counter, latch that digit's nibble and dp, and go to DRIVE.
  - DRIVE: an drives the current index low. The counter counts 0..DIGIT_CYCLES-1; at terminal count, clear the counter, increment the index mod 4, and go to BLANK.
  - frame_tick is asserted in the same cycle the index changes from 3 to 0.
- Digit content:
  - idx0 = mag[3:0], idx1 = mag[7:4], idx2 = b, idx3 = a.
  - dp = ~neg_captured on idx1; dp = 1 on all other digits.
  - No leading-zero blanking.
- Decoder table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Output timing:
  - seg, dp, an and frame_tick are registered outputs; no combinational path from inputs to outputs.
  - Exactly one anode is low in DRIVE and none in BLANK.
  - Full frame period = 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- Boundary cases:
  - neg=1 with diff=8'h80 gives mag=8'h80 with dp lit.
  - neg=0 with diff[7]=1 is displayed as an unsigned value.
  - A load edge and a phase transition in the same cycle: both take effect, and the new phase uses the pre-capture values.
- Counter widths come from $clog2 of the larger parameter.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=2):
- Reset release with load=0 → scan order an 1111(2 cycles), 1110(4), 1111(2), 1101(4), 1111(2), 1011(4), 1111(2), 0111(4); seg=1000000 on every digit; dp=1; frame_tick pulses once per 24 cycles.
- a=4'h9, b=4'h3, diff=8'h06, neg=0, load pulse → next frame shows digit3=0010000, digit2=0110000, digit1=1000000, digit0=0000010; dp stays 1.
- a=4'h3, b=4'h9, diff=8'hFA, neg=1, load → mag=8'h06; digit1=1000000 with dp=0; digit0=0000010.
- diff=8'h80, neg=1, load → digit1=0000000 with dp=0, digit0=1000000; then load held high for 50 cycles with inputs changed → exactly one capture, display unchanged.
- Assert rst_n=0 mid-DRIVE of idx2 → an=1111 and seg=1111111 asynchronously; after release, captured values are 0 and scanning restarts at BLANK then idx0.
- Load edge whose capture lands during idx0 DRIVE → idx0 keeps its old value until the next frame, and idx1..3 show new values this frame; check for X on any output and that an is never multi-hot.
